// File: rtl/fir_ss_fifo.sv
// First-word-fall-through AXI-Stream FIFO feeding the FIR slave stream port.
// Define FIFO_LEVEL_EN to expose the registered occupancy count on fifo_level.
module fir_ss_fifo #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 8,
    parameter int pPTR_WIDTH  = 3
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast,
    input  logic                   sm_tready
`ifdef FIFO_LEVEL_EN
    ,
    output logic [pPTR_WIDTH:0]    fifo_level
`endif
);

    localparam logic [pPTR_WIDTH:0] PTR_ONE = {{pPTR_WIDTH{1'b0}}, 1'b1};

    logic [pDATA_WIDTH:0] mem [pDEPTH];
    logic [pDATA_WIDTH:0] head;
    logic [pPTR_WIDTH:0]  wr_ptr, rd_ptr;
    logic [pPTR_WIDTH:0]  wr_ptr_nxt, rd_ptr_nxt;
    logic                 ready_r;
    logic                 empty;
    logic                 full_nxt;
    logic                 push, pop;

    function automatic logic is_full(input logic [pPTR_WIDTH:0] wp,
                                     input logic [pPTR_WIDTH:0] rp);
        return (wp[pPTR_WIDTH-1:0] == rp[pPTR_WIDTH-1:0]) &&
               (wp[pPTR_WIDTH] != rp[pPTR_WIDTH]);
    endfunction

    assign empty = (wr_ptr == rd_ptr);
    assign push  = ss_tvalid & ready_r;
    assign pop   = ~empty & sm_tready;

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (push) wr_ptr_nxt = wr_ptr + PTR_ONE;
        if (pop)  rd_ptr_nxt = rd_ptr + PTR_ONE;
        full_nxt = is_full(wr_ptr_nxt, rd_ptr_nxt);
    end

    // Ready is registered from the next-state pointers so it never depends on sm_tready
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ready_r <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            ready_r <= ~full_nxt;
        end
    end

    // Storage is data-only: never reset, written only on an accepted beat
    always_ff @(posedge axis_clk) begin
        if (push) mem[wr_ptr[pPTR_WIDTH-1:0]] <= {ss_tlast, ss_tdata};
    end

    assign head      = mem[rd_ptr[pPTR_WIDTH-1:0]];
    assign ss_tready = ready_r;
    assign sm_tvalid = ~empty;
    assign sm_tdata  = empty ? '0   : head[pDATA_WIDTH-1:0];
    assign sm_tlast  = empty ? 1'b0 : head[pDATA_WIDTH];

`ifdef FIFO_LEVEL_EN
    logic [pPTR_WIDTH:0] count;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + PTR_ONE;
                2'b01:   count <= count - PTR_ONE;
                default: count <= count;
            endcase
        end
    end

    assign fifo_level = count;
`endif

endmodule

// File: tb/tb_fir_ss_fifo.sv
// Directed scoreboard bench for fir_ss_fifo; expected beats are queued on accept
// and compared in order when the FIFO hands them out.
module tb_fir_ss_fifo;

    localparam int DW = 32;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ss_tvalid = 1'b0;
    logic [DW-1:0] ss_tdata = '0;
    logic          ss_tlast = 1'b0;
    logic          ss_tready;
    logic          sm_tvalid;
    logic [DW-1:0] sm_tdata;
    logic          sm_tlast;
    logic          sm_tready = 1'b0;
`ifdef FIFO_LEVEL_EN
    logic [PW:0]   fifo_level;
`endif

    fir_ss_fifo #(.pDATA_WIDTH(DW), .pDEPTH(8), .pPTR_WIDTH(PW)) dut (
        .axis_clk   (clk),
        .axis_rst_n (rst_n),
        .ss_tvalid  (ss_tvalid),
        .ss_tdata   (ss_tdata),
        .ss_tlast   (ss_tlast),
        .ss_tready  (ss_tready),
        .sm_tvalid  (sm_tvalid),
        .sm_tdata   (sm_tdata),
        .sm_tlast   (sm_tlast),
        .sm_tready  (sm_tready)
`ifdef FIFO_LEVEL_EN
        ,
        .fifo_level (fifo_level)
`endif
    );

    always #5 clk = ~clk;

    logic [DW:0] sb[$];
    int          pass_cnt = 0;
    int          total    = 0;
    logic        acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Handshakes are evaluated at the falling edge, between input updates.
    task automatic tick();
        logic [DW:0] e;
        @(negedge clk);
        if (sm_tvalid && sm_tready) begin
            if (sb.size() == 0) begin
                check("pop_with_empty_model", {63'd0, sm_tvalid}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("sm_beat", {31'd0, sm_tlast, sm_tdata}, {31'd0, e});
            end
        end
        acc = ss_tvalid && ss_tready;
        if (acc) sb.push_back({ss_tlast, ss_tdata});
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        ss_tvalid = 1'b0;
        sm_tready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, sb.size(), 0);
        check({tag, "_empty_valid"}, {63'd0, sm_tvalid}, 64'd0);
        sm_tready = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        ss_tvalid = 1'b1;
        ss_tdata  = d;
        ss_tlast  = l;
        tick();
    endtask

    initial begin
        logic [DW:0] held;
        int sent;
        int cyc;

        // 1: reset and release
        repeat (2) tick();
        check("rst_ready", {63'd0, ss_tready}, 64'd0);
        check("rst_valid", {63'd0, sm_tvalid}, 64'd0);
        rst_n = 1'b1;
        tick();
        check("rel_ready", {63'd0, ss_tready}, 64'd1);
        check("rel_valid", {63'd0, sm_tvalid}, 64'd0);
        check("rel_data", {32'd0, sm_tdata}, 64'd0);
        check("rel_last", {63'd0, sm_tlast}, 64'd0);
`ifdef FIFO_LEVEL_EN
        check("rel_level", {60'd0, fifo_level}, 64'd0);
`endif

        // 2: three beats with the sink always ready
        sm_tready = 1'b1;
        send(32'd5, 1'b0);
        check("lat_valid", {63'd0, sm_tvalid}, 64'd1);
        check("lat_data", {32'd0, sm_tdata}, 64'd5);
        send(-32'sd3, 1'b0);
        send(32'd7, 1'b1);
        drain("t2");

        // 3: fill to full, hold the ninth beat, release one slot
        for (int i = 1; i <= 8; i++) send(i[DW-1:0], 1'b0);
        check("full_ready", {63'd0, ss_tready}, 64'd0);
`ifdef FIFO_LEVEL_EN
        check("full_level", {60'd0, fifo_level}, 64'd8);
`endif
        send(32'd9, 1'b1);
        check("held_not_taken", {63'd0, acc}, 64'd0);
        check("held_ready", {63'd0, ss_tready}, 64'd0);
        sm_tready = 1'b1;
        tick();
        check("pop_frees_ready", {63'd0, ss_tready}, 64'd1);
        sm_tready = 1'b0;
        tick();
        check("ninth_taken", {63'd0, acc}, 64'd1);
        drain("t3");

        // 4: sustained traffic with a sink ready one cycle in three
        sent = 0;
        cyc  = 0;
        ss_tvalid = 1'b1;
        while (sent < 400 && cyc < 5000) begin
            ss_tdata  = 32'h1000 + sent * 37;
            ss_tlast  = (sent % 8) == 7;
            sm_tready = (cyc % 3) == 0;
            tick();
            if (acc) sent++;
            cyc++;
        end
        check("t4_all_sent", sent, 400);
        drain("t4");

        // 5: reset with beats buffered
        for (int i = 0; i < 4; i++) send(32'hA0 + i, 1'b0);
        ss_tvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, sm_tvalid}, 64'd0);
        check("mid_rst_ready", {63'd0, ss_tready}, 64'd0);
        sb.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", {63'd0, ss_tready}, 64'd1);
        check("post_rst_valid", {63'd0, sm_tvalid}, 64'd0);
`ifdef FIFO_LEVEL_EN
        check("post_rst_level", {60'd0, fifo_level}, 64'd0);
`endif
        send(32'h11, 1'b0);
        check("post_rst_first", {32'd0, sm_tdata}, 64'h11);
        drain("t5");

        // 6: head beat stays put while the sink stalls
        sm_tready = 1'b0;
        send(32'hCAFE, 1'b1);
        held = {1'b1, 32'hCAFE};
        for (int i = 0; i < 10; i++) begin
            send(32'h200 + i, 1'b0);
            check("hold_beat", {31'd0, sm_tlast, sm_tdata}, {31'd0, held});
            check("hold_valid", {63'd0, sm_tvalid}, 64'd1);
        end
        drain("t6");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
